// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b data cache types and block helpers
package lc3b_types;

    typedef logic [127:0] lc3b_block;
    typedef logic [8:0]   lc3b_dc_tag;
    typedef logic [2:0]   lc3b_dc_index;
    typedef logic [3:0]   lc3b_dc_offset;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL,
        RESP
    } lc3b_dc_state;

    // Extract the 16-bit word at word offset w of a block.
    function automatic logic [15:0] block_word(input lc3b_block blk, input logic [2:0] w);
        return blk[{w, 4'b0000} +: 16];
    endfunction

    // Merge the byte-enabled lanes of data into word w of a block.
    function automatic lc3b_block block_merge(input lc3b_block blk, input logic [2:0] w,
                                              input logic [1:0] mask, input logic [15:0] data);
        lc3b_block r;
        r = blk;
        if (mask[0]) r[{w, 4'b0000} +: 8] = data[7:0];
        if (mask[1]) r[{w, 4'b1000} +: 8] = data[15:8];
        return r;
    endfunction

endpackage

// File: rtl/lc3b_dcache_array.sv
// rtl/lc3b_dcache_array.sv - valid/dirty/tag/data storage for the data cache
module dcache_array
    import lc3b_types::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 12 - IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] index_i,
    output logic             valid_o,
    output logic             dirty_o,
    output logic [TAG_W-1:0] tag_o,
    output lc3b_block        data_o,
    input  logic             valid_we_i,
    input  logic             valid_i,
    input  logic             dirty_we_i,
    input  logic             dirty_i,
    input  logic             tag_we_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             data_we_i,
    input  lc3b_block        data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    lc3b_block            data_q [NUM_LINES];

    // Status bits: cleared on reset so every line starts invalid and clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (valid_we_i) valid_q[index_i] <= valid_i;
            if (dirty_we_i) dirty_q[index_i] <= dirty_i;
        end
    end

    // Tag and data payload: never reset, only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (tag_we_i)  tag_q[index_i]  <= tag_i;
        if (data_we_i) data_q[index_i] <= data_i;
    end

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign data_o  = data_q[index_i];

endmodule

// File: rtl/lc3b_dcache.sv
// rtl/lc3b_dcache.sv - direct-mapped write-back write-allocate data cache for the load/store queue
module lc3b_dcache
    import lc3b_types::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [1:0]   wmask,
    input  logic [15:0]  address,
    input  logic [15:0]  wdata,
    output logic         resp,
    output logic [15:0]  rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 12 - IDX_W;

    lc3b_dc_state state_q;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic [2:0]       addr_word;
    logic             addr_unused;
    logic             req;
    logic             hit;

    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    lc3b_block        line_data;

    logic             valid_we;
    logic             valid_in;
    logic             dirty_we;
    logic             dirty_in;
    logic             tag_we;
    logic             data_we;
    lc3b_block        data_in;

    assign addr_tag    = address[15:4+IDX_W];
    assign addr_idx    = address[4+IDX_W-1:4];
    assign addr_word   = address[3:1];
    // Byte lane selection for byte loads happens in the requester.
    assign addr_unused = address[0];
    assign req         = read | write;
    assign hit         = line_valid && (line_tag == addr_tag);

    dcache_array #(
        .NUM_LINES (NUM_LINES)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .index_i    (addr_idx),
        .valid_o    (line_valid),
        .dirty_o    (line_dirty),
        .tag_o      (line_tag),
        .data_o     (line_data),
        .valid_we_i (valid_we),
        .valid_i    (valid_in),
        .dirty_we_i (dirty_we),
        .dirty_i    (dirty_in),
        .tag_we_i   (tag_we),
        .tag_i      (addr_tag),
        .data_we_i  (data_we),
        .data_i     (data_in)
    );

    // Controller: physical transactions always run to completion once started.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (hit)                           state_q <= RESP;
                        else if (line_valid && line_dirty) state_q <= WRITEBACK;
                        else                               state_q <= FILL;
                    end
                end
                WRITEBACK: if (pmem_resp) state_q <= FILL;
                FILL:      if (pmem_resp) state_q <= req ? RESP : IDLE;
                RESP:      state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // Array updates: victim cleaned after writeback, fill installed, store merged only on resp.
    always_comb begin
        valid_we = 1'b0;
        valid_in = 1'b0;
        dirty_we = 1'b0;
        dirty_in = 1'b0;
        tag_we   = 1'b0;
        data_we  = 1'b0;
        data_in  = pmem_rdata;
        if (!reset) begin
            case (state_q)
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty_we = 1'b1;
                        dirty_in = 1'b0;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_we = 1'b1;
                        valid_in = 1'b1;
                        dirty_we = 1'b1;
                        dirty_in = 1'b0;
                        tag_we   = 1'b1;
                        data_we  = 1'b1;
                    end
                end
                RESP: begin
                    if (write) begin
                        dirty_we = 1'b1;
                        dirty_in = 1'b1;
                        data_we  = 1'b1;
                        data_in  = block_merge(line_data, addr_word, wmask, wdata);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state register and the registered arrays only.
    always_comb begin
        resp         = (state_q == RESP) && req;
        rdata        = resp ? block_word(line_data, addr_word) : 16'h0000;
        pmem_read    = (state_q == FILL);
        pmem_write   = (state_q == WRITEBACK);
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        if (state_q == WRITEBACK) begin
            pmem_address = {line_tag, addr_idx, 4'b0000};
            pmem_wdata   = line_data;
        end else if (state_q == FILL) begin
            pmem_address = {address[15:4], 4'b0000};
        end
    end

endmodule

// File: tb/tb_lc3b_dcache.sv
// tb/tb_lc3b_dcache.sv - self-checking bench for lc3b_dcache
module tb_lc3b_dcache;

    logic         clk;
    logic         reset;
    logic         read;
    logic         write;
    logic [1:0]   wmask;
    logic [15:0]  address;
    logic [15:0]  wdata;
    logic         resp;
    logic [15:0]  rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    int checks   = 0;
    int failures = 0;

    lc3b_dcache dut (
        .clk          (clk),
        .reset        (reset),
        .read         (read),
        .write        (write),
        .wmask        (wmask),
        .address      (address),
        .wdata        (wdata),
        .resp         (resp),
        .rdata        (rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Physical memory and the architectural (coherent) view of every word.
    logic [127:0] mem  [bit [11:0]];
    logic [15:0]  gold [bit [14:0]];

    function automatic logic [15:0] init_word(input logic [14:0] wa);
        return ({1'b0, wa} * 16'd37) ^ 16'hC3A5;
    endfunction

    function automatic logic [127:0] mem_block(input logic [11:0] b);
        logic [127:0] r;
        if (mem.exists(b)) return mem[b];
        for (int w = 0; w < 8; w++) r[w*16 +: 16] = init_word({b, 3'(w)});
        return r;
    endfunction

    function automatic logic [15:0] gold_word(input logic [14:0] wa);
        logic [127:0] blk;
        if (gold.exists(wa)) return gold[wa];
        blk = mem_block(wa[14:3]);
        return blk[int'(wa[2:0])*16 +: 16];
    endfunction

    function automatic logic [127:0] gold_block(input logic [11:0] b);
        logic [127:0] r;
        for (int w = 0; w < 8; w++) r[w*16 +: 16] = gold_word({b, 3'(w)});
        return r;
    endfunction

    // Which block each line holds, and whether the cache owns the only up-to-date copy.
    bit          mv [8];
    logic [8:0]  mt [8];
    bit          md [8];

    // Memory responder: fixed latency pm_lat cycles per transaction.
    int           pm_lat = 5;
    int           busy   = 0;
    logic [11:0]  wb_q   [$];
    logic [11:0]  fill_q [$];
    logic [127:0] last_wb_data;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
                busy       = 0;
            end
            if (!reset && (pmem_read || pmem_write)) begin
                busy++;
                if (busy >= pm_lat) begin
                    chk("pmem_addr_align", pmem_address[3:0], 4'h0);
                    if (pmem_write) begin
                        chk("wb_block_data", pmem_wdata, gold_block(pmem_address[15:4]));
                        last_wb_data = pmem_wdata;
                        mem[pmem_address[15:4]] = pmem_wdata;
                        wb_q.push_back(pmem_address[15:4]);
                    end else begin
                        pmem_rdata = mem_block(pmem_address[15:4]);
                        fill_q.push_back(pmem_address[15:4]);
                    end
                    pmem_resp = 1'b1;
                end
            end else begin
                busy = 0;
            end
        end
    end

    bit mon_en = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("pmem_rw_exclusive", pmem_read & pmem_write, 1'b0);
                if (!resp) chk("rdata_zero_without_resp", rdata, 16'h0);
            end
        end
    end

    task automatic drive_req(input bit wr, input logic [15:0] a, input logic [1:0] m,
                             input logic [15:0] d, input bit withdraw,
                             output bit got, output int lat, output logic [15:0] rd);
        wb_q.delete();
        fill_q.delete();
        got = 0;
        lat = 0;
        rd  = 16'h0;
        @(posedge clk);
        #1;
        address = a;
        wmask   = m;
        wdata   = d;
        read    = !wr;
        write   = wr;
        if (!withdraw) begin
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (resp) begin
                    got = 1;
                    rd  = rdata;
                end else begin
                    lat++;
                end
            end
            @(posedge clk);
            #1;
            read  = 1'b0;
            write = 1'b0;
        end else begin
            for (int c = 0; c < 400 && !pmem_read; c++) @(negedge clk);
            chk("withdraw_fill_started", pmem_read, 1'b1);
            @(posedge clk);
            #1;
            read  = 1'b0;
            write = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (resp) got = 1;
            end
        end
    endtask

    task automatic model_commit(input bit wr, input logic [15:0] a, input logic [1:0] m,
                                input logic [15:0] d, input bit withdrawn);
        int idx;
        logic [15:0] o;
        idx = int'(a[6:4]);
        if (!(mv[idx] && mt[idx] == a[15:7])) begin
            mv[idx] = 1;
            mt[idx] = a[15:7];
            md[idx] = 0;
        end
        if (wr && !withdrawn) begin
            md[idx] = 1;
            o = gold_word(a[15:1]);
            if (m[0]) o[7:0]  = d[7:0];
            if (m[1]) o[15:8] = d[15:8];
            gold[a[15:1]] = o;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            if (mv[i] && md[i])
                for (int w = 0; w < 8; w++) gold.delete({mt[i], 3'(i), 3'(w)});
            mv[i] = 0;
            md[i] = 0;
        end
    endtask

    task automatic model_req(input bit wr, input logic [15:0] a, input logic [1:0] m,
                             input logic [15:0] d, input bit try_withdraw);
        int idx, lat, exp_lat;
        bit hit, dirty, wd, got;
        logic [15:0] rd, exp_rd;
        logic [11:0] victim;
        idx     = int'(a[6:4]);
        hit     = mv[idx] && (mt[idx] == a[15:7]);
        dirty   = mv[idx] && md[idx] && !hit;
        victim  = {mt[idx], a[6:4]};
        wd      = try_withdraw && !hit;
        exp_rd  = gold_word(a[15:1]);
        exp_lat = hit ? 1 : (dirty ? 2*pm_lat + 1 : pm_lat + 1);
        drive_req(wr, a, m, d, wd, got, lat, rd);
        chk($sformatf("req_resp a=%h wd=%0d", a, wd), got, !wd);
        chk($sformatf("req_wb_count a=%h", a), wb_q.size(), dirty);
        if (dirty && wb_q.size() > 0) chk($sformatf("req_wb_addr a=%h", a), wb_q[0], victim);
        chk($sformatf("req_fill_count a=%h", a), fill_q.size(), !hit);
        if (!hit && fill_q.size() > 0) chk($sformatf("req_fill_addr a=%h", a), fill_q[0], a[15:4]);
        if (!wd) begin
            chk($sformatf("req_latency a=%h", a), lat, exp_lat);
            if (!wr) chk($sformatf("req_rdata a=%h", a), rd, exp_rd);
        end
        model_commit(wr, a, m, d, wd);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [1:0]  m;
        logic [15:0] d;
        int          lat;
        bit          chk_rd;
        logic [15:0] rd;
        bit          wb;
        logic [11:0] wb_blk;
        bit          fill;
        logic [11:0] fill_blk;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [127:0] blk;
        logic [15:0]  iw, rd;
        logic [3:0]   pat;
        bit           got;
        int           lat, gap;
        bit           wr;
        logic [15:0]  a;

        reset   = 1'b1;
        read    = 1'b0;
        write   = 1'b0;
        wmask   = 2'b00;
        address = 16'h0;
        wdata   = 16'h0;
        for (int i = 0; i < 8; i++) begin
            mv[i] = 0;
            md[i] = 0;
            mt[i] = 9'h0;
        end

        // Block 0x123 holds 0xBEEF in word 2.
        blk = mem_block(12'h123);
        blk[47:32] = 16'hBEEF;
        mem[12'h123] = blk;

        tbl[0] = '{0, 16'h1234, 2'b00, 16'h0000,  6, 1, 16'hBEEF, 0, 12'h000, 1, 12'h123};
        tbl[1] = '{0, 16'h1234, 2'b00, 16'h0000,  1, 1, 16'hBEEF, 0, 12'h000, 0, 12'h000};
        tbl[2] = '{1, 16'h1235, 2'b10, 16'hAAAA,  1, 0, 16'h0000, 0, 12'h000, 0, 12'h000};
        tbl[3] = '{0, 16'h1234, 2'b00, 16'h0000,  1, 1, 16'hAAEF, 0, 12'h000, 0, 12'h000};
        tbl[4] = '{0, 16'h1334, 2'b00, 16'h0000, 11, 1, init_word(15'h099A), 1, 12'h123, 1, 12'h133};
        tbl[5] = '{0, 16'h1230, 2'b00, 16'h0000,  6, 1, init_word(15'h0918), 1, 12'h133, 1, 12'h123};
        tbl[6] = '{1, 16'h0042, 2'b01, 16'h1177,  6, 0, 16'h0000, 0, 12'h000, 1, 12'h004};
        iw = init_word(15'h0021);
        tbl[7] = '{0, 16'h0042, 2'b00, 16'h0000,  1, 1, {iw[15:8], 8'h77}, 0, 12'h000, 0, 12'h000};
        // Vector 5 evicts 0x133, which is clean: no writeback expected after all.
        tbl[5].wb = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", resp, 1'b0);
        chk("reset_rdata", rdata, 16'h0);
        chk("reset_pmem_read", pmem_read, 1'b0);
        chk("reset_pmem_write", pmem_write, 1'b0);
        chk("reset_pmem_address", pmem_address, 16'h0);
        chk("reset_pmem_wdata", pmem_wdata, 128'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1;

        pm_lat = 5;
        for (int i = 0; i < 8; i++) begin
            drive_req(tbl[i].wr, tbl[i].a, tbl[i].m, tbl[i].d, 0, got, lat, rd);
            chk($sformatf("vec%0d_resp", i), got, 1'b1);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_wb_count", i), wb_q.size(), tbl[i].wb);
            if (tbl[i].wb && wb_q.size() > 0) chk($sformatf("vec%0d_wb_addr", i), wb_q[0], tbl[i].wb_blk);
            chk($sformatf("vec%0d_fill_count", i), fill_q.size(), tbl[i].fill);
            if (tbl[i].fill && fill_q.size() > 0) chk($sformatf("vec%0d_fill_addr", i), fill_q[0], tbl[i].fill_blk);
            if (i == 4) chk("vec4_wb_word2", last_wb_data[47:32], 16'hAAEF);
            if (got) model_commit(tbl[i].wr, tbl[i].a, tbl[i].m, tbl[i].d, 0);
        end

        // Store to a missing line withdrawn during FILL: line installed clean, store dropped.
        drive_req(1, 16'h2266, 2'b11, 16'h1111, 1, got, lat, rd);
        chk("withdraw_no_resp", got, 1'b0);
        chk("withdraw_fill_addr", (fill_q.size() == 1) ? fill_q[0] : 12'hFFF, 12'h226);
        model_commit(1, 16'h2266, 2'b11, 16'h1111, 1);
        drive_req(0, 16'h2266, 2'b00, 16'h0, 0, got, lat, rd);
        chk("withdraw_then_hit_latency", lat, 1);
        chk("withdraw_then_hit_rdata", rd, init_word(15'h1133));
        chk("withdraw_then_hit_no_fill", fill_q.size(), 0);

        // Read held through a hit response yields a second response two cycles later.
        @(posedge clk);
        #1;
        address = 16'h2266;
        read    = 1'b1;
        pat     = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pat[c] = resp;
        end
        @(posedge clk);
        #1;
        read = 1'b0;
        chk("held_read_resp_pattern", pat, 4'b1010);
        repeat (2) @(negedge clk);

        // Drop after resp, re-raise three cycles later: exactly one response each time.
        drive_req(0, 16'h2266, 2'b00, 16'h0, 0, got, lat, rd);
        gap = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp) gap++;
        end
        chk("dropped_read_gap_resps", gap, 0);
        drive_req(0, 16'h2266, 2'b00, 16'h0, 0, got, lat, rd);
        chk("reraised_read_resp", got, 1'b1);
        chk("reraised_read_latency", lat, 1);

        // Reset during FILL drops the transaction and invalidates everything.
        pm_lat = 10;
        @(posedge clk);
        #1;
        address = 16'h3350;
        read    = 1'b1;
        for (int c = 0; c < 50 && !pmem_read; c++) @(negedge clk);
        chk("reset_fill_started", pmem_read, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        read  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_fill_pmem_read", pmem_read, 1'b0);
        chk("reset_mid_fill_pmem_write", pmem_write, 1'b0);
        model_reset();
        pm_lat = 3;
        model_req(0, 16'h1334, 2'b00, 16'h0, 0);

        // Randomised traffic over four tags per index against the reference model.
        for (int n = 0; n < 200; n++) begin
            pm_lat = $urandom_range(1, 4);
            wr     = 1'($urandom_range(0, 1));
            a      = {9'h040 + 9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15))};
            model_req(wr, a, 2'($urandom_range(0, 3)), 16'($urandom),
                      $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3b_dcache.md
# lc3b_dcache

Data-side memory responder for the out-of-order core. It sits between the load/store queue's memory port and physical memory. It services the queue's level-held read/write requests from a direct-mapped, write-back, write-allocate cache and answers each completed request with a one-cycle `resp` pulse. It tolerates requests that are withdrawn mid-flight, which happens when the load/store queue flushes.

## Interface
- `NUM_LINES`, 8: number of cache lines, power of two. Index width = log2(NUM_LINES).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `read` in 1: load request, held high until `resp` or withdrawal.
- `write` in 1: store request, held high until `resp` or withdrawal. Never high together with `read`.
- `wmask` in 2: byte enables for stores. Bit0 = low byte, bit1 = high byte.
- `address` in 16: byte address, stable while the request is held.
- `wdata` in 16: store data, byte-lane aligned.
- `resp` out 1: one-cycle completion pulse.
- `rdata` out 16: aligned word at `address[3:1]`. Valid only while `resp` = 1, otherwise 0.
- `pmem_read` out 1: block read request, held until `pmem_resp`.
- `pmem_write` out 1: block write request, held until `pmem_resp`.
- `pmem_address` out 16: block-aligned address, low 4 bits always 0.
- `pmem_wdata` out 128: victim block.
- `pmem_resp` in 1: physical memory completion pulse.
- `pmem_rdata` in 128: fill block, valid while `pmem_resp` = 1.

## Operation
- Address split: tag = `address[15:7]`, index = `address[6:4]`, word = `address[3:1]`. Byte lane selection for byte loads is done by the requester, not here.
- Per line: valid, dirty, 9-bit tag, 128-bit data.
- FSM states: IDLE, WRITEBACK, FILL, RESP.
- IDLE:
  - No request: stay.
  - Request that hits: go to RESP.
  - Request that misses, victim clean or invalid: go to FILL.
  - Request that misses, victim valid and dirty: go to WRITEBACK.
- WRITEBACK:
  - `pmem_write` = 1, `pmem_address` = {victim tag, index, 4'b0}, `pmem_wdata` = victim data.
  - On `pmem_resp`: clear dirty, go to FILL.
- FILL:
  - `pmem_read` = 1, `pmem_address` = {`address[15:4]`, 4'b0}.
  - On `pmem_resp`: install `pmem_rdata`, tag, valid = 1, dirty = 0.
  - Then go to RESP if `read|write` is still high, otherwise go to IDLE.
- RESP:
  - If `read|write` is high: `resp` = 1 and `rdata` = selected word.
  - If `write` is high: merge `wdata` into the enabled bytes of that word and set dirty.
  - If the request was withdrawn: `resp` = 0 and no array update.
  - Always go to IDLE next.
- Withdrawal during WRITEBACK/FILL: the physical transaction always runs to completion and is never aborted. The fill is installed. No `resp` is issued. No store data is merged.
- A store is applied to the array only in the cycle its `resp` is asserted.
- After RESP the FSM returns to IDLE. A request still high in that IDLE cycle is a new request and yields a second `resp`.
- `pmem_read` and `pmem_write` are never high simultaneously.

## Timing
- Reset values:
  - State IDLE; all valid and dirty bits cleared.
  - `resp`, `rdata`, `pmem_read`, `pmem_write` = 0; `pmem_address` = 0; `pmem_wdata` = 0.
  - Data and tag arrays are not cleared.
- Reset mid-WRITEBACK/FILL: `pmem_*` requests are low the next cycle, and any outstanding physical transaction is dropped.
- Request sampled in IDLE at cycle 0:
  - Hit: `resp` in cycle 1.
  - Clean miss: `pmem_read` from cycle 1. `pmem_resp` in cycle F gives `resp` in F+1.
  - Dirty miss: `pmem_write` from cycle 1. `pmem_resp` at W, then `pmem_read` from W+1, `pmem_resp` at F, then `resp` at F+1.
- Outputs are decoded from state and registered arrays. There is no combinational path from `pmem_resp` to `resp`.
- Hit/miss is decided from `address` as sampled in IDLE. The requester holds `address` stable, so there is no re-check.

## Structure
- Add to `lc3b_types`:
  - `lc3b_block` (128-bit), `lc3b_dc_tag` (9), `lc3b_dc_index` (3), `lc3b_dc_offset` (4).
  - Enum `lc3b_dc_state` with IDLE, WRITEBACK, FILL, RESP.
- Sub-module `dcache_array`:
  - Valid/dirty/tag/data storage for `NUM_LINES` entries.
  - Combinational read by index; one synchronous write port with separate valid/dirty/tag/data enables; synchronous clear of valid/dirty on `reset`.
- The top level holds the FSM, hit compare, word select and store merge.

## Test plan
- Reset, read 0x1234: `pmem_read` with `pmem_address` 0x1230 held 5 cycles; `pmem_rdata` word2 = 0xBEEF → `resp` once, `rdata` 0xBEEF. Re-read 0x1234 → `resp` next cycle, no pmem activity.
- Store 0x1235, `wmask` 2'b10, `wdata` 0xAAAA (line resident) → `resp` in 1 cycle. Read 0x1234 → 0xAAEF.
- Then read 0x1334 (same index, different tag) → `pmem_write` at 0x1230 with word2 0xAAEF, then `pmem_read` 0x1330, then `resp` with fill data.
- Store to a missing line, drop `write` during FILL → fill installed clean, no `resp`, no merge. Later read of that address hits with the unmodified value.
- Assert `reset` during FILL → `pmem_read` low next cycle. Subsequent read of a previously resident address misses.
- `read` held high through `resp` on a hit → second `resp` two cycles later. Drop `read` after `resp`, re-raise 3 cycles later → single `resp`.
